// File: rtl/vip_hist_stat_pp_pkg.sv
// Shared definitions for the frame histogram collector: counter sizing,
// default pixel width and the frame-control state encoding.
package vip_hist_stat_pp_pkg;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  localparam int BITS_DEF      = 32'sd8;
  localparam int FRAME_PIXELS  = 32'sd640 * 32'sd480;
  localparam int HIST_BITS_DEF = clogb2(FRAME_PIXELS);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } hist_state_e;

endpackage

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of an address written in the same cycle returns the old word.
module simple_dp_ram #(
  parameter int WIDTH  = 19,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [0:(1<<ADDR_W)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its word while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/vip_hist_stat_pp.sv
// Frame histogram collector with ping-pong banks. Pixels of frame N are
// accumulated into the write bank by a two-stage read-modify-write pipeline
// while the downstream stage reads frame N-1 from the other bank. A vsync
// rise swaps the banks and sweeps the new write bank back to zero.
module vip_hist_stat_pp
  import vip_hist_stat_pp_pkg::*;
#(
  parameter int BITS      = BITS_DEF,
  parameter int HIST_BITS = HIST_BITS_DEF
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic [BITS-1:0]      in_data,
  input  logic                 out_en,
  input  logic [BITS-1:0]      out_addr,
  output logic [HIST_BITS-1:0] out_data,
  output logic                 frame_done,
  output logic                 stat_busy,
  output logic                 err_flag
);

  localparam logic [HIST_BITS-1:0] CNT_MAX    = {HIST_BITS{1'b1}};
  localparam logic [HIST_BITS-1:0] CNT_ZERO   = {HIST_BITS{1'b0}};
  localparam logic [BITS:0]        INIT_LAST  = {(BITS+1){1'b1}};
  localparam logic [BITS:0]        CLEAR_LAST = {1'b0, {BITS{1'b1}}};
  localparam logic [BITS:0]        SWEEP_ZERO = {(BITS+1){1'b0}};
  localparam logic [BITS-1:0]      ADDR_ZERO  = {BITS{1'b0}};

  // Frame control
  hist_state_e         state_r;
  logic [BITS:0]       sweep_cnt_r;
  logic                bank_sel_r;     // write bank; the other one is read
  logic                prev_vsync_r;
  logic                frame_done_r;
  logic                busy_r;
  logic                err_r;

  logic                swap_evt_s;
  logic                px_acc_s;
  logic                err_set_s;
  logic                sweep_on_s;
  logic                sweep_bank_s;

  // Accumulate pipeline: S1 stage plus the two most recent writes
  logic                s1_vld_r;
  logic [BITS-1:0]     s1_addr_r;
  logic                s1_bank_r;
  logic                w1_vld_r;
  logic [BITS-1:0]     w1_addr_r;
  logic                w1_bank_r;
  logic [HIST_BITS-1:0] w1_data_r;
  logic                w2_vld_r;
  logic [BITS-1:0]     w2_addr_r;
  logic                w2_bank_r;
  logic [HIST_BITS-1:0] w2_data_r;
  logic [HIST_BITS-1:0] base_s;
  logic [HIST_BITS-1:0] new_s;

  // External read path
  logic                out_vld_r;
  logic                out_bank_r;
  logic                out_zero_r;
  logic [HIST_BITS-1:0] hold_r;
  logic [HIST_BITS-1:0] out_data_s;

  logic [HIST_BITS-1:0] rdata_s [0:1];

  assign swap_evt_s   = in_vsync & ~prev_vsync_r;
  assign px_acc_s     = in_href & (state_r == ST_RUN);
  assign err_set_s    = (in_href & (state_r != ST_RUN)) |
                        (swap_evt_s & (state_r == ST_CLEAR));
  assign sweep_on_s   = (state_r != ST_RUN);
  assign sweep_bank_s = (state_r == ST_INIT) ? sweep_cnt_r[BITS] : bank_sel_r;

  // Frame control: INIT/CLEAR sweeps, bank swap, done pulse, busy and sticky error.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r      <= ST_INIT;
      sweep_cnt_r  <= SWEEP_ZERO;
      bank_sel_r   <= 1'b0;
      prev_vsync_r <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b1;
      err_r        <= 1'b0;
    end else begin
      prev_vsync_r <= in_vsync;
      frame_done_r <= 1'b0;
      err_r        <= err_r | err_set_s;
      case (state_r)
        ST_INIT: begin
          if (sweep_cnt_r == INIT_LAST) begin
            state_r     <= ST_RUN;
            busy_r      <= 1'b0;
            sweep_cnt_r <= SWEEP_ZERO;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + 1'b1;
          end
        end
        ST_RUN: begin
          if (swap_evt_s) begin
            bank_sel_r   <= ~bank_sel_r;
            frame_done_r <= 1'b1;
            state_r      <= ST_CLEAR;
            busy_r       <= 1'b1;
            sweep_cnt_r  <= SWEEP_ZERO;
          end else begin
            sweep_cnt_r  <= SWEEP_ZERO;
          end
        end
        ST_CLEAR: begin
          if (sweep_cnt_r == CLEAR_LAST) begin
            state_r     <= ST_RUN;
            busy_r      <= 1'b0;
            sweep_cnt_r <= SWEEP_ZERO;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r     <= ST_INIT;
          busy_r      <= 1'b1;
          sweep_cnt_r <= SWEEP_ZERO;
        end
      endcase
    end
  end

  // S1 source select: youngest matching in-flight write wins over RAM data; saturating increment.
  always_comb begin
    base_s = rdata_s[s1_bank_r];
    if (w1_vld_r && (w1_addr_r == s1_addr_r) && (w1_bank_r == s1_bank_r)) begin
      base_s = w1_data_r;
    end else if (w2_vld_r && (w2_addr_r == s1_addr_r) && (w2_bank_r == s1_bank_r)) begin
      base_s = w2_data_r;
    end else begin
      base_s = rdata_s[s1_bank_r];
    end
    if (base_s == CNT_MAX) begin
      new_s = CNT_MAX;
    end else begin
      new_s = base_s + 1'b1;
    end
  end

  // Accumulate pipeline registers and write history used for forwarding.
  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_vld_r  <= 1'b0;
      s1_addr_r <= ADDR_ZERO;
      s1_bank_r <= 1'b0;
      w1_vld_r  <= 1'b0;
      w1_addr_r <= ADDR_ZERO;
      w1_bank_r <= 1'b0;
      w1_data_r <= CNT_ZERO;
      w2_vld_r  <= 1'b0;
      w2_addr_r <= ADDR_ZERO;
      w2_bank_r <= 1'b0;
      w2_data_r <= CNT_ZERO;
    end else begin
      s1_vld_r  <= px_acc_s;
      s1_addr_r <= in_data;
      s1_bank_r <= bank_sel_r;
      w1_vld_r  <= s1_vld_r;
      w1_addr_r <= s1_addr_r;
      w1_bank_r <= s1_bank_r;
      w1_data_r <= new_s;
      w2_vld_r  <= w1_vld_r;
      w2_addr_r <= w1_addr_r;
      w2_bank_r <= w1_bank_r;
      w2_data_r <= w1_data_r;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    localparam logic BANK_ID = (g == 1);

    logic                 we_s;
    logic [BITS-1:0]      waddr_s;
    logic [HIST_BITS-1:0] wdata_s;
    logic                 re_s;
    logic [BITS-1:0]      raddr_s;

    // Port steering: sweep beats RMW on the write port; the write bank serves RMW reads, the other external reads.
    always_comb begin
      we_s    = 1'b0;
      waddr_s = ADDR_ZERO;
      wdata_s = CNT_ZERO;
      if (sweep_on_s && (sweep_bank_s == BANK_ID)) begin
        we_s    = 1'b1;
        waddr_s = sweep_cnt_r[BITS-1:0];
        wdata_s = CNT_ZERO;
      end else if (s1_vld_r && (s1_bank_r == BANK_ID)) begin
        we_s    = 1'b1;
        waddr_s = s1_addr_r;
        wdata_s = new_s;
      end else begin
        we_s    = 1'b0;
      end
      if (bank_sel_r == BANK_ID) begin
        re_s    = 1'b1;
        raddr_s = in_data;
      end else begin
        re_s    = out_en;
        raddr_s = out_addr;
      end
    end

    simple_dp_ram #(
      .WIDTH  (HIST_BITS),
      .ADDR_W (BITS)
    ) u_ram (
      .clk   (pclk),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .re    (re_s),
      .raddr (raddr_s),
      .rdata (rdata_s[g])
    );
  end

  // Capture which bank an external read targets and whether it happened during INIT.
  always_ff @(posedge pclk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_bank_r <= 1'b0;
      out_zero_r <= 1'b0;
      hold_r     <= CNT_ZERO;
    end else begin
      out_vld_r  <= out_en;
      out_bank_r <= ~bank_sel_r;
      out_zero_r <= (state_r == ST_INIT);
      hold_r     <= out_data_s;
    end
  end

  // Present the read-bank word one cycle after out_en; otherwise keep the last word.
  always_comb begin
    if (!out_vld_r) begin
      out_data_s = hold_r;
    end else if (out_zero_r) begin
      out_data_s = CNT_ZERO;
    end else begin
      out_data_s = rdata_s[out_bank_r];
    end
  end

  assign out_data   = out_data_s;
  assign frame_done = frame_done_r;
  assign stat_busy  = busy_r;
  assign err_flag   = err_r;

endmodule

// File: tb/tb_vip_hist_stat_pp.sv
// Self-checking bench for vip_hist_stat_pp: directed frames, a table of
// expected bins, randomized frames against a frame-level histogram model,
// error cases, mid-frame reset and counter saturation on a narrow instance.
module tb_vip_hist_stat_pp;

  localparam int BITS   = 8;
  localparam int HB     = 19;
  localparam int NB     = 256;
  localparam int SAT_HB = 4;

  logic            pclk = 1'b0;
  logic            rst, in_href, in_vsync, out_en;
  logic [BITS-1:0] in_data, out_addr;
  logic [HB-1:0]   out_data;
  logic            frame_done, stat_busy, err_flag;

  logic              s_rst, s_href, s_vsync, s_out_en;
  logic [BITS-1:0]   s_data, s_out_addr;
  logic [SAT_HB-1:0] s_out_data;
  logic              s_frame_done, s_busy, s_err;

  int checks = 0;
  int errors = 0;
  int hist_w [NB];
  int hist_r [NB];

  typedef struct {
    int bin;
    int exp;
  } rd_vec_t;

  always #5 pclk = ~pclk;

  vip_hist_stat_pp #(.BITS(BITS), .HIST_BITS(HB)) dut (
    .pclk(pclk), .rst(rst), .in_href(in_href), .in_vsync(in_vsync),
    .in_data(in_data), .out_en(out_en), .out_addr(out_addr),
    .out_data(out_data), .frame_done(frame_done), .stat_busy(stat_busy),
    .err_flag(err_flag)
  );

  vip_hist_stat_pp #(.BITS(BITS), .HIST_BITS(SAT_HB)) dut_sat (
    .pclk(pclk), .rst(s_rst), .in_href(s_href), .in_vsync(s_vsync),
    .in_data(s_data), .out_en(s_out_en), .out_addr(s_out_addr),
    .out_data(s_out_data), .frame_done(s_frame_done), .stat_busy(s_busy),
    .err_flag(s_err)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_cnt(input int c, input int hb);
    int mx;
    mx = (1 << hb) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      hist_w[i] = 0;
      hist_r[i] = 0;
    end
  endtask

  task automatic model_swap();
    for (int i = 0; i < NB; i++) begin
      hist_r[i] = hist_w[i];
      hist_w[i] = 0;
    end
  endtask

  task automatic send_px(input int v);
    in_href = 1'b1;
    in_data = 8'(v);
    tick();
    hist_w[v] = hist_w[v] + 1;
  endtask

  task automatic idle(input int n);
    in_href = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_busy_low(input string name, input int exp_len);
    int n;
    n = 0;
    while (stat_busy && n < 2000) begin
      tick();
      n++;
    end
    chk(name, n, exp_len);
  endtask

  task automatic frame_end();
    idle(3);
    in_vsync = 1'b1;
    tick();
    model_swap();
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_at_swap", stat_busy, 1);
    tick();
    chk("frame_done_fall", frame_done, 0);
    wait_busy_low("clear_len", 255);
    in_vsync = 1'b0;
    tick();
  endtask

  task automatic read_bin(input int a, output int v);
    out_en   = 1'b1;
    out_addr = 8'(a);
    tick();
    out_en   = 1'b0;
    v        = int'(out_data);
  endtask

  task automatic read_all(input string name);
    for (int a = 0; a < NB; a++) begin
      out_en   = 1'b1;
      out_addr = 8'(a);
      tick();
      chk($sformatf("%s[%0d]", name, a), out_data, sat_cnt(hist_r[a], HB));
    end
    out_en = 1'b0;
    tick();
    chk({name, "_hold"}, out_data, sat_cnt(hist_r[NB-1], HB));
  endtask

  initial begin
    rd_vec_t tbl1 [8];
    rd_vec_t tbl2 [3];
    rd_vec_t tbl3 [2];
    int n;
    int v;

    tbl1[0] = '{7, 100};  tbl1[1] = '{3, 100};  tbl1[2] = '{5, 100};
    tbl1[3] = '{0, 0};    tbl1[4] = '{4, 0};    tbl1[5] = '{6, 0};
    tbl1[6] = '{8, 0};    tbl1[7] = '{255, 0};
    tbl2[0] = '{20, 80};  tbl2[1] = '{10, 0};   tbl2[2] = '{21, 0};
    tbl3[0] = '{9, 0};    tbl3[1] = '{2, 5};

    rst = 1'b1; in_href = 1'b0; in_vsync = 1'b0; in_data = '0;
    out_en = 1'b0; out_addr = '0;
    s_rst = 1'b1; s_href = 1'b0; s_vsync = 1'b0; s_data = '0;
    s_out_en = 1'b0; s_out_addr = '0;
    model_reset();

    // Reset values
    tick(); tick();
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", stat_busy, 1);
    chk("rst_err", err_flag, 0);
    rst = 1'b0;

    // INIT: 512 busy cycles, reads during INIT return 0
    n = 0;
    while (stat_busy && n < 2000) begin
      out_en   = 1'b1;
      out_addr = 8'(n);
      tick();
      n++;
      if (out_data !== '0) chk($sformatf("init_read[%0d]", n), out_data, 0);
    end
    out_en = 1'b0;
    chk("init_len", n, 512);
    read_all("init_bins");

    // Frame: 100 x 7 back-to-back, then alternating 3/5 x100 each
    for (int i = 0; i < 100; i++) send_px(7);
    for (int i = 0; i < 100; i++) begin
      send_px(3);
      send_px(5);
    end
    frame_end();
    for (int i = 0; i < 8; i++) begin
      read_bin(tbl1[i].bin, v);
      chk($sformatf("tbl1_bin%0d", tbl1[i].bin), v, tbl1[i].exp);
    end
    read_all("frame1");

    // Two frames: A = 50 x 10, B = 80 x 20; B's bank must have been cleared
    for (int i = 0; i < 50; i++) send_px(10);
    frame_end();
    for (int i = 0; i < 80; i++) send_px(20);
    frame_end();
    for (int i = 0; i < 3; i++) begin
      read_bin(tbl2[i].bin, v);
      chk($sformatf("tbl2_bin%0d", tbl2[i].bin), v, tbl2[i].exp);
    end

    // Randomized frames: narrow value range (dense hazards), then full range
    for (int f = 0; f < 3; f++) begin
      int len;
      len = $urandom_range(200, 600);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          if (f == 0) send_px($urandom_range(0, 3));
          else if (f == 1) send_px($urandom_range(0, 1));
          else send_px($urandom_range(0, 255));
        end else begin
          idle(1);
        end
      end
      frame_end();
      read_all($sformatf("rand%0d", f));
    end

    // Pixel inside CLEAR is dropped and flagged; second rise in CLEAR is ignored
    for (int i = 0; i < 30; i++) send_px(9);
    idle(3);
    in_vsync = 1'b1;
    tick();
    model_swap();
    chk("err_frame_done", frame_done, 1);
    repeat (99) tick();
    chk("in_clear_busy", stat_busy, 1);
    chk("err_before", err_flag, 0);
    in_href = 1'b1; in_data = 8'd9;
    tick();
    in_href = 1'b0;
    chk("err_after_drop", err_flag, 1);
    in_vsync = 1'b0;
    tick();
    in_vsync = 1'b1;
    tick();
    chk("no_done_in_clear", frame_done, 0);
    tick();
    chk("no_done_in_clear2", frame_done, 0);
    wait_busy_low("clear_len_err", 153);
    in_vsync = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send_px(2);
    frame_end();
    for (int i = 0; i < 2; i++) begin
      read_bin(tbl3[i].bin, v);
      chk($sformatf("tbl3_bin%0d", tbl3[i].bin), v, tbl3[i].exp);
    end
    chk("err_sticky", err_flag, 1);

    // Reset mid-frame after 40 pixels
    read_bin(2, v);
    chk("pre_rst_bin2", v, 5);
    for (int i = 0; i < 40; i++) send_px($urandom_range(0, 255));
    rst = 1'b1;
    in_href = 1'b0;
    tick();
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_busy", stat_busy, 1);
    chk("mid_rst_err", err_flag, 0);
    rst = 1'b0;
    model_reset();
    wait_busy_low("init_len_rerun", 512);
    read_all("after_rst");

    // Saturation on a 4-bit counter instance: 20 pixels of value 1
    s_rst = 1'b0;
    n = 0;
    while (s_busy && n < 2000) begin
      tick();
      n++;
    end
    chk("sat_init_len", n, 512);
    for (int i = 0; i < 20; i++) begin
      s_href = 1'b1; s_data = 8'd1;
      tick();
    end
    s_href = 1'b0;
    repeat (3) tick();
    s_vsync = 1'b1;
    tick();
    chk("sat_frame_done", s_frame_done, 1);
    n = 0;
    while (s_busy && n < 2000) begin
      tick();
      n++;
    end
    chk("sat_clear_len", n, 256);
    s_vsync = 1'b0;
    s_out_en = 1'b1; s_out_addr = 8'd1;
    tick();
    chk("sat_bin1", s_out_data, sat_cnt(20, SAT_HB));
    s_out_addr = 8'd0;
    tick();
    chk("sat_bin0", s_out_data, 0);
    s_out_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
